ac_ctrl: RTL and testbench
==========================

AC_CTRL -- requirements
Module: ac_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the accumulator data width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-006 The block SHALL have port req_op, input, 3 bits: opcode (0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 CLR, 7 illegal).
REQ-007 The block SHALL have port req_data, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port ac_in, input, WIDTH bits: the current accumulator register value.
REQ-009 The block SHALL have port z, output, WIDTH bits: the next accumulator value, driving the accumulator Z bus.
REQ-010 The block SHALL have port load_ac, output, 1 bit: a one-cycle load strobe to the accumulator.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1 bit: the last request was illegal; sticky until the next accepted request.

Function
REQ-013 The FSM SHALL have states IDLE, OPER, LOAD and DONE, encoded as an enum from the package.
REQ-014 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid and req_ready are both 1 on a clk edge.
REQ-015 On a handshake, op and data SHALL be registered; the FSM SHALL go IDLE->OPER, and err SHALL clear.
REQ-016 In OPER, the block SHALL capture ac_in, compute the result into a z register and go to LOAD.
- LOAD: z = data.
- ADD: z = ac + data, mod 2^WIDTH.
- SUB: z = ac - data, mod 2^WIDTH.
- AND: z = ac & data.
- OR: z = ac | data.
- CLR: z = 0.
- NOP: z = ac.
REQ-017 In LOAD, load_ac SHALL be 1 for exactly that cycle, with z stable; the FSM SHALL then go to DONE.
REQ-018 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL then return to IDLE.
- Handshake-to-load_ac latency: 2 cycles.
- Handshake-to-done latency: 3 cycles.
- Back-to-back throughput: one op per 4 cycles.
REQ-019 NOP SHALL follow the full sequence but hold load_ac at 0.
REQ-020 Opcode 7 SHALL go OPER->DONE without load_ac, set err=1 and pulse done.
REQ-021 z SHALL hold its last value outside LOAD.
REQ-022 req_valid asserted while req_ready=0 SHALL be ignored; the requester holds the request until ready.
REQ-023 req_op and req_data changing after the handshake SHALL have no effect on the operation in flight.

Reset
REQ-024 While reset=1 at a clk edge, the FSM SHALL go to IDLE and z, load_ac, done and err SHALL be 0; req_ready SHALL be 1 on the cycle after reset deasserts.
REQ-025 Reset in OPER, LOAD or DONE SHALL abort the operation; no load_ac SHALL be issued after reset, including in the same cycle.
REQ-026 Reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-027 With the macro AC_CTRL_FLAGS_EN defined, the block SHALL add output ports zf and cf, 1 bit each, both reset to 0 and updated only in LOAD.
- zf = (z == 0).
- cf = carry-out of ADD, borrow of SUB, 0 otherwise.
REQ-028 Without AC_CTRL_FLAGS_EN, ports zf and cf and their logic SHALL be absent, with all other behaviour identical.

Structure
REQ-029 Package ac_pkg SHALL hold the opcode enum ac_op_t, the state enum ac_state_t and localparam AC_W = 8.
REQ-030 Result computation SHALL be in the combinational sub-module ac_alu (inputs op, a, b; outputs y and carry); ac_ctrl SHALL own the FSM and registers.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, then LOAD 0x5A -> load_ac on the 2nd cycle after handshake with z=0x5A; done on the 3rd.
- ac_in=0xF0, ADD 0x20 -> z=0x10; with flags: cf=1, zf=0.
- ac_in=0x05, SUB 0x05 -> z=0x00; with flags: zf=1, cf=0.
- req_op=7 -> no load_ac, err=1, done pulses; the next LOAD 0x01 clears err.
- reset asserted in OPER after ADD -> no load_ac, state IDLE, req_ready=1 after reset deasserts.
- req_valid held high with alternating ops -> handshakes exactly 4 cycles apart; NOP gives no load_ac.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared types for the accumulator controller: opcode and FSM state enums, default data width.
package ac_pkg;
  localparam int AC_W = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_CLR  = 3'd6,
    OP_ILL  = 3'd7
  } ac_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } ac_state_t;
endpackage

// File: rtl/ac_alu.sv
// Combinational result for one accumulator op; carry is ADD carry-out or SUB borrow, else 0.
module ac_alu
  import ac_pkg::*;
#(
  parameter int WIDTH = AC_W
) (
  input  ac_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of a zero-extended difference is the borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = a;
    carry = 1'b0;
    case (op)
      OP_LOAD: y = b;
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        y     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_CLR:  y = '0;
      default: y = a;
    endcase
  end
endmodule

// File: rtl/ac_ctrl.sv
// Accumulator controller: IDLE->OPER->LOAD->DONE per request, load_ac 2 and done 3 cycles after handshake.
// Optional zf/cf flag outputs are built when AC_CTRL_FLAGS_EN is defined.
module ac_ctrl
  import ac_pkg::*;
#(
  parameter int WIDTH = AC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] ac_in,
  output logic [WIDTH-1:0] z,
  output logic             load_ac,
  output logic             done,
  output logic             err
`ifdef AC_CTRL_FLAGS_EN
  ,
  output logic             zf,
  output logic             cf
`endif
);
  ac_state_t        state, state_n;
  ac_op_t           op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] z_q;
  logic             err_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             hs;

  assign req_ready = (state == IDLE);
  assign hs        = req_valid && req_ready;
  assign z         = z_q;
  assign err       = err_q;

  ac_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op_q),
    .a     (ac_in),
    .b     (data_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    load_ac = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (hs) state_n = OPER;
      OPER: state_n = (op_q == OP_ILL) ? DONE : LOAD;
      LOAD: begin
        load_ac = (op_q != OP_NOP);
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Strobes are gated by reset so an aborted op never loads, even mid-cycle.
    if (reset) begin
      load_ac = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_NOP;
      data_q <= '0;
      z_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (hs) begin
        op_q   <= ac_op_t'(req_op);
        data_q <= req_data;
        err_q  <= 1'b0;
      end
      if (state == OPER) begin
        if (op_q == OP_ILL) err_q <= 1'b1;
        else                z_q   <= alu_y;
      end
    end
  end

`ifdef AC_CTRL_FLAGS_EN
  logic carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      zf      <= 1'b0;
      cf      <= 1'b0;
    end else begin
      if (state == OPER) carry_q <= alu_carry;
      if (state == LOAD) begin
        zf <= (z_q == '0);
        cf <= carry_q;
      end
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif
endmodule

// File: tb/tb_ac_ctrl.sv
// Self-checking bench for ac_ctrl: directed vector table, corner sequences, random traffic vs cycle-level model.
module tb_ac_ctrl;
  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic [7:0] ac_in;
  logic [7:0] z;
  logic       load_ac;
  logic       done;
  logic       err;
`ifdef AC_CTRL_FLAGS_EN
  logic       zf;
  logic       cf;
`endif

  ac_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .ac_in     (ac_in),
    .z         (z),
    .load_ac   (load_ac),
    .done      (done),
    .err       (err)
`ifdef AC_CTRL_FLAGS_EN
    ,
    .zf        (zf),
    .cf        (cf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks expected timing as cycle numbers rather than FSM states.
  int  cyc = 0;
  int  ready_cyc = 0;
  int  load_cyc = -1;
  int  done_cyc = -1;
  int  oper_cyc = -1;
  int  m_op = 0;
  int  m_data = 0;
  int  mz = 0;
  bit  merr = 0;
  bit  mcarry = 0;
  bit  mzf = 0;
  bit  mcf = 0;

  function automatic int alu_ref(input int op, input int d, input int a, output bit c);
    c = 1'b0;
    case (op)
      1: return d;
      2: begin c = (a + d) > 255; return (a + d) % 256; end
      3: begin c = a < d; return (a - d + 256) % 256; end
      4: return a & d;
      5: return a | d;
      6: return 0;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      ready_cyc = cyc; load_cyc = -1; done_cyc = -1; oper_cyc = -1;
      mz = 0; merr = 0; mzf = 0; mcf = 0; mcarry = 0;
    end else begin
      if (oper_cyc >= 0 && cyc == oper_cyc + 1) begin
        if (m_op == 7) merr = 1;
        else mz = alu_ref(m_op, m_data, int'(ac_in), mcarry);
      end
      if (oper_cyc >= 0 && cyc == oper_cyc + 2 && m_op != 7) begin
        mzf = (mz == 0);
        mcf = mcarry;
      end
      if (req_valid && (cyc - 1) >= ready_cyc) begin
        m_op = int'(req_op); m_data = int'(req_data); oper_cyc = cyc; merr = 0;
        if (m_op == 7) begin
          load_cyc = -1; done_cyc = cyc + 1; ready_cyc = cyc + 2;
        end else begin
          load_cyc = (m_op == 0) ? -1 : cyc + 1;
          done_cyc = cyc + 2; ready_cyc = cyc + 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", req_ready, cyc >= ready_cyc);
      check("m_load_ac", load_ac, (cyc == load_cyc) && !reset);
      check("m_done", done, (cyc == done_cyc) && !reset);
      check("m_z", z, mz);
      check("m_err", err, merr);
`ifdef AC_CTRL_FLAGS_EN
      check("m_zf", zf, mzf);
      check("m_cf", cf, mcf);
`endif
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] ac;
    logic [7:0] exp_z;
    logic       exp_err;
    int         exp_load_k;
    int         exp_done_k;
    logic       exp_zf;
    logic       exp_cf;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
  endtask

  int load_k, done_k, nload, nhs, lds, loads_seen, last;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd1, 8'h5A, 8'h33, 8'h5A, 1'b0, 2, 3, 1'b0, 1'b0};
    vecs[1] = '{3'd2, 8'h20, 8'hF0, 8'h10, 1'b0, 2, 3, 1'b0, 1'b1};
    vecs[2] = '{3'd3, 8'h05, 8'h05, 8'h00, 1'b0, 2, 3, 1'b1, 1'b0};
    vecs[3] = '{3'd7, 8'h12, 8'h77, 8'h00, 1'b1, 0, 2, 1'b1, 1'b0};
    vecs[4] = '{3'd1, 8'h01, 8'h00, 8'h01, 1'b0, 2, 3, 1'b0, 1'b0};
    vecs[5] = '{3'd4, 8'h0F, 8'h3C, 8'h0C, 1'b0, 2, 3, 1'b0, 1'b0};
    vecs[6] = '{3'd5, 8'h0F, 8'h30, 8'h3F, 1'b0, 2, 3, 1'b0, 1'b0};
    vecs[7] = '{3'd6, 8'h55, 8'hAA, 8'h00, 1'b0, 2, 3, 1'b1, 1'b0};
    vecs[8] = '{3'd0, 8'h55, 8'h42, 8'h42, 1'b0, 0, 3, 1'b0, 1'b0};
    vecs[9] = '{3'd3, 8'h01, 8'h00, 8'hFF, 1'b0, 2, 3, 1'b0, 1'b1};

    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00; ac_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_z", z, 0);
    check("rst_load_ac", load_ac, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    chk_en = 1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", req_ready, 1);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      wait_ready();
      req_valid = 1'b1; req_op = vecs[i].op; req_data = vecs[i].data; ac_in = vecs[i].ac;
      load_k = 0; done_k = 0; nload = 0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (load_ac) begin nload++; if (load_k == 0) load_k = k; end
        if (done && done_k == 0) done_k = k;
        if (k == 1) begin req_valid = 1'b0; req_op = 3'($urandom); req_data = 8'($urandom); end
        if (k == 2) ac_in = 8'($urandom);
      end
      check($sformatf("v%0d_z", i), z, vecs[i].exp_z);
      check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("v%0d_load_k", i), load_k, vecs[i].exp_load_k);
      check($sformatf("v%0d_nload", i), nload, (vecs[i].exp_load_k != 0) ? 1 : 0);
      check($sformatf("v%0d_done_k", i), done_k, vecs[i].exp_done_k);
`ifdef AC_CTRL_FLAGS_EN
      check($sformatf("v%0d_zf", i), zf, vecs[i].exp_zf);
      check($sformatf("v%0d_cf", i), cf, vecs[i].exp_cf);
`endif
    end

    // Back-to-back requests with req_valid held high, alternating LOAD/NOP.
    wait_ready();
    req_valid = 1'b1; nhs = 0; lds = 0; loads_seen = 0; last = -1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (load_ac) loads_seen++;
      if (req_ready) begin
        if (last >= 0) check("b2b_gap", i - last, 4);
        last = i; nhs++;
        req_op = (nhs % 2 == 1) ? 3'd1 : 3'd0;
        if (req_op == 3'd1) lds++;
        req_data = 8'($urandom);
      end
    end
    req_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (load_ac) loads_seen++;
    end
    check("b2b_handshakes", nhs, 4);
    check("b2b_loads", loads_seen, lds);

    // Reset during OPER after an ADD.
    wait_ready();
    req_valid = 1'b1; req_op = 3'd2; req_data = 8'h10; ac_in = 8'h01;
    @(posedge clk); #2 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("rst_oper_ready", req_ready, 1);
    check("rst_oper_z", z, 0);
    nload = 0;
    repeat (3) begin
      @(negedge clk);
      if (load_ac || done) nload++;
    end
    check("rst_oper_no_strobe", nload, 0);

    // Reset asserted mid-LOAD suppresses load_ac in that same cycle.
    wait_ready();
    req_valid = 1'b1; req_op = 3'd1; req_data = 8'h77; ac_in = 8'h00;
    @(posedge clk); #2 req_valid = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check("rst_load_same_cycle", load_ac, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    check("rst_load_z", z, 0);
    check("rst_load_ready", req_ready, 1);

    // Random traffic, including stray resets and requests while busy.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      reset     = ($urandom_range(0, 59) == 0);
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 3'($urandom);
      req_data  = 8'($urandom);
      ac_in     = 8'($urandom);
    end
    @(posedge clk); #2 reset = 1'b0; req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
